// File: rtl/adder_pkg.sv
// Shared state encoding and helpers for the chunked serial adder.
// CSA_SIGNED_OVF_EN adds the signed overflow output.
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/chunked_serial_adder_ripple_chunk.sv
// Combinational CHUNK-bit ripple adder slice.
// cmsb is the carry into the top bit of the slice.
module ripple_chunk #(
    parameter int CHUNK = 2
) (
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             cmsb,
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co   = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle A+B+cin adder, CHUNK bits per clock, valid/ready on both sides.
// CSA_SIGNED_OVF_EN adds the registered signed overflow output ovf.
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSA_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (clog2(NCHUNK) > 0) ? clog2(NCHUNK) : 1;

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("chunked_serial_adder: CHUNK must divide WIDTH");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic              carry_q, cout_q;
    logic [CW-1:0]     cnt_q;
    logic [CHUNK-1:0]  s;
    logic              co;
    logic              last;

    assign last = (cnt_q == CW'(NCHUNK - 1));

`ifdef CSA_SIGNED_OVF_EN
    logic cmsb;
    logic ovf_q;

    ripple_chunk #(.CHUNK(CHUNK)) u_chunk (
        .s(s), .co(co), .cmsb(cmsb),
        .x(a_q[CHUNK-1:0]), .y(b_q[CHUNK-1:0]), .ci(carry_q)
    );
`else
    ripple_chunk #(.CHUNK(CHUNK)) u_chunk (
        .s(s), .co(co), .cmsb(),
        .x(a_q[CHUNK-1:0]), .y(b_q[CHUNK-1:0]), .ci(carry_q)
    );
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (in_valid) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && in_valid) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= cin;
                cnt_q   <= '0;
            end else if (state_q == S_RUN) begin
                // operands shift down so the slice always sees the next chunk
                sum_q[cnt_q*CHUNK +: CHUNK] <= s;
                a_q     <= a_q >> CHUNK;
                b_q     <= b_q >> CHUNK;
                carry_q <= co;
                cnt_q   <= cnt_q + 1'b1;
                if (last) cout_q <= co;
            end
        end
    end

`ifdef CSA_SIGNED_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == S_RUN && last) begin
            ovf_q <= cmsb ^ co;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Randomised bench for chunked_serial_adder against a transaction-level model.
// Optional ovf checks follow CSA_SIGNED_OVF_EN.
module tb_chunked_serial_adder;

    localparam int W = 8;
    localparam int C = 2;
    localparam int N = W / C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid = 0, in_ready, cin = 0, out_valid, out_ready = 0, cout;
    logic [W-1:0] a = 0, b = 0, sum;
    logic         in_valid1 = 0, in_ready1, cin1 = 0, out_valid1, out_ready1 = 0, cout1;
    logic [15:0]  a1 = 0, b1 = 0, sum1;
`ifdef CSA_SIGNED_OVF_EN
    logic ovf, ovf1;
`endif

    chunked_serial_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef CSA_SIGNED_OVF_EN
        , .ovf(ovf)
`endif
    );

    chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
`ifdef CSA_SIGNED_OVF_EN
        , .ovf(ovf1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic bit sovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > 127) || (s < -128);
    endfunction

    // transaction model: one op in flight, result due N edges after accept
    int         cyc = 0;
    int         acc = 0;
    bit         busy = 0;
    logic [W:0] exp_r = 0, hold_r = 0;
    bit         exp_o = 0, hold_o = 0;
    bit         mon_en = 0;

    always @(posedge clk or posedge rst) begin
        cyc <= cyc + 1;
        if (rst) begin
            busy   <= 0;
            hold_r <= 0;
            hold_o <= 0;
        end else if (!busy && in_valid) begin
            busy  <= 1;
            acc   <= cyc + 1;
            exp_r <= {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            exp_o <= sovf(a, b, cin);
        end else if (busy && (cyc + 1 - acc > N) && out_ready) begin
            busy   <= 0;
            hold_r <= exp_r;
            hold_o <= exp_o;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", 32'(in_ready), 32'(!busy));
            chk("out_valid", 32'(out_valid), 32'(busy && (cyc - acc >= N)));
            if (busy && (cyc - acc >= N)) begin
                chk("sum", 32'(sum), 32'(exp_r[W-1:0]));
                chk("cout", 32'(cout), 32'(exp_r[W]));
`ifdef CSA_SIGNED_OVF_EN
                chk("ovf", 32'(ovf), 32'(exp_o));
`endif
            end else if (!busy) begin
                chk("sum_hold", 32'(sum), 32'(hold_r[W-1:0]));
                chk("cout_hold", 32'(cout), 32'(hold_r[W]));
`ifdef CSA_SIGNED_OVF_EN
                chk("ovf_hold", 32'(ovf), 32'(hold_o));
`endif
            end
        end
    end

    task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                            output int lat, output logic [W-1:0] s, output logic co);
        @(negedge clk);
        a = x; b = y; cin = c; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        if (!out_valid) chk("directed_timeout", 0, 1);
        s  = sum;
        co = cout;
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input int stall);
        bit done = 0;
        @(negedge clk);
        a = x; b = y; cin = c; in_valid = 1; out_ready = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            in_valid = 1'($urandom);
            if (out_valid) begin
                if (stall > 0) begin
                    out_ready = 0;
                    stall--;
                end else begin
                    out_ready = 1;
                    @(negedge clk);
                    out_ready = 0;
                    in_valid = 0;
                    done = 1;
                end
            end else begin
                out_ready = 1'($urandom);
            end
        end
        if (!done) chk("run_op_timeout", 0, 1);
    endtask

    int         lat;
    logic [W-1:0] s;
    logic       co;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        rst = 0;
        mon_en = 1;

        directed(8'd100, 8'd99, 1'b0, lat, s, co);
        chk("lat_100_99", 32'(lat), 4);
        chk("sum_100_99", 32'(s), 32'hC7);
        chk("cout_100_99", 32'(co), 0);

        directed(8'd178, 8'd134, 1'b0, lat, s, co);
        chk("sum_178_134", 32'(s), 32'h38);
        chk("cout_178_134", 32'(co), 1);

        directed(8'hFF, 8'h00, 1'b1, lat, s, co);
        chk("sum_ff_00_1", 32'(s), 32'h00);
        chk("cout_ff_00_1", 32'(co), 1);

`ifdef CSA_SIGNED_OVF_EN
        directed(8'h7F, 8'h01, 1'b0, lat, s, co);
        chk("sum_7f_01", 32'(s), 32'h80);
        chk("ovf_7f_01", 32'(ovf), 1);
`endif

        // long backpressure with junk in_valid while busy
        run_op(8'd77, 8'd200, 1'b1, 10);

        // abort in the second RUN cycle
        @(negedge clk);
        a = 8'd9; b = 8'd5; cin = 0; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_sum", 32'(sum), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 0;

        directed(8'd22, 8'd33, 1'b0, lat, s, co);
        chk("sum_22_33", 32'(s), 55);

        repeat (30) run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        // single-chunk instance: one-cycle latency
        @(negedge clk);
        a1 = 16'hFFFF; b1 = 16'h0001; cin1 = 0; in_valid1 = 1;
        @(posedge clk);
        #1 in_valid1 = 0;
        chk("w16_in_ready_busy", 32'(in_ready1), 0);
        @(posedge clk);
        #1;
        chk("w16_out_valid", 32'(out_valid1), 1);
        chk("w16_sum", 32'(sum1), 0);
        chk("w16_cout", 32'(cout1), 1);
        out_ready1 = 1;
        @(posedge clk);
        #1 out_ready1 = 0;
        chk("w16_in_ready", 32'(in_ready1), 1);

        for (int i = 0; i < 8; i++) begin
            logic [16:0] e;
            @(negedge clk);
            a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom); in_valid1 = 1;
            e = {1'b0, a1} + {1'b0, b1} + 17'(cin1);
            @(posedge clk);
            #1 in_valid1 = 0;
            @(posedge clk);
            #1;
            chk("w16_rand_valid", 32'(out_valid1), 1);
            chk("w16_rand_sum", 32'(sum1), 32'(e[15:0]));
            chk("w16_rand_cout", 32'(cout1), 32'(e[16]));
            out_ready1 = 1;
            @(posedge clk);
            #1 out_ready1 = 0;
        end

        repeat (2) @(negedge clk);
        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
